// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Registered program-counter select stage for the instruction fetch port.
//   It advances the PC on each accepted fetch and holds it while fetch stalls.
//   Four redirect sources take precedence over the stall. In priority order
//   they are trap, return, jump and branch. A circular return-address stack
//   records link addresses on jump+call and supplies targets on return.
//
// Parameters
//   PC_W       PC and target width in bits
//   PC_INC     sequential increment applied on each accepted fetch
//   RESET_VEC  PC loaded by reset
//   TRAP_VEC   target on trap and on return-stack underflow
//   RAS_DEPTH  return-stack entries (>=2, power of two)
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   synchronous reset, active low
//   fetch_ready    in   fetch unit accepts pc_out this cycle
//   branch         in   taken branch, redirect to branch_target
//   branch_target  in   branch destination
//   jump           in   unconditional jump, redirect to jump_target
//   jump_target    in   jump destination
//   call           in   with a winning jump: push pc_out+PC_INC
//   ret            in   redirect to top of stack, then pop
//   trap           in   redirect to TRAP_VEC, stack untouched
//   pc_out         out  current fetch address
//   pc_valid       out  pc_out is valid for fetch
//   ras_empty      out  stack holds no entries
//   ras_full       out  stack holds RAS_DEPTH entries
//   ras_underflow  out  one-cycle pulse: ret issued on an empty stack
// ----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int unsigned       PC_W      = 16,
   parameter int unsigned       PC_INC    = 1,
   parameter logic [PC_W-1:0]   RESET_VEC = '0,
   parameter logic [PC_W-1:0]   TRAP_VEC  = PC_W'(16'hFFF0),
   parameter int unsigned       RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_ready,
   input  logic            branch,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            call,
   input  logic            ret,
   input  logic            trap,
   output logic [PC_W-1:0] pc_out,
   output logic            pc_valid,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_underflow
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  pc_q, pc_d;
   logic             valid_q;
   logic [PTR_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             underflow_q, underflow_d;
   logic             push;
   logic [PC_W-1:0]  link;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];

   assign link = pc_q + PC_W'(PC_INC);

   // Redirect selection: the if/else chain encodes trap > ret > jump > branch.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      pc_d        = pc_q;
      top_d       = top_q;
      count_d     = count_q;
      underflow_d = 1'b0;
      push        = 1'b0;

      if (trap) begin
         pc_d = TRAP_VEC;
      end else if (ret) begin
         if (count_q != '0) begin
            pc_d    = ras_q[top_q];
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
         end else begin
            pc_d        = TRAP_VEC;
            underflow_d = 1'b1;
         end
      end else if (jump) begin
         pc_d = jump_target;
         if (call) begin
            // When full, top+1 is the oldest slot, so the push overwrites it.
            push  = 1'b1;
            top_d = top_q + PTR_W'(1);
            if (count_q != CNT_FULL) begin
               count_d = count_q + CNT_W'(1);
            end
         end
      end else if (branch) begin
         pc_d = branch_target;
      end else if (valid_q && fetch_ready) begin
         pc_d = link;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         pc_q        <= RESET_VEC;
         valid_q     <= 1'b0;
         top_q       <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         valid_q     <= 1'b1;
         top_q       <= top_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: stack storage is not reset; a zero count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         ras_q[top_d] <= link;
      end
   end

   assign pc_out        = pc_q;
   assign pc_valid      = valid_q;
   assign ras_empty     = (count_q == '0);
   assign ras_full      = (count_q == CNT_FULL);
   assign ras_underflow = underflow_q;

endmodule
